// File: rtl/univ_shift_reg_if.sv
// Bus bundle for the universal shift register: preset/enable/operation
// controls and serial/parallel data in, register contents and flags out.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic             PRE;
    logic             E;
    logic [2:0]       MODE;
    logic [WIDTH-1:0] D;
    logic             SI_L;
    logic             SI_R;
    logic [WIDTH-1:0] Q;
    logic             SO_L;
    logic             SO_R;
    logic             TC;

    // Driver side: supplies controls and data, observes the register.
    modport master (
        output PRE, E, MODE, D, SI_L, SI_R,
        input  Q, SO_L, SO_R, TC
    );

    // Register side.
    modport slave (
        input  PRE, E, MODE, D, SI_L, SI_R,
        output Q, SO_L, SO_R, TC
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, serial shift left/right,
// rotate left/right, and modulo up/down count with a one-cycle wrap flag.
// Synchronous active-high reset, synchronous active-low preset.
module univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] PRE_VAL = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                 CLK,
    input  logic                 RST,
    univ_shift_reg_if.slave      bus
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_INC  = 3'b110,
        OP_DEC  = 3'b111
    } op_e;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    op_e              op;

    assign op = op_e'(bus.MODE);

    // Next-state selection: preset beats enable; TC only pulses on a count wrap.
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (!bus.PRE) begin
            q_d = PRE_VAL;
        end else if (bus.E) begin
            unique case (op)
                OP_HOLD: q_d = q_q;
                OP_LOAD: q_d = bus.D;
                OP_SHL:  q_d = {q_q[WIDTH-2:0], bus.SI_L};
                OP_SHR:  q_d = {bus.SI_R, q_q[WIDTH-1:1]};
                OP_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                OP_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                OP_INC: begin
                    q_d  = q_q + ONE;
                    tc_d = (q_q == ALL_ONES);
                end
                OP_DEC: begin
                    q_d  = q_q - ONE;
                    tc_d = (q_q == '0);
                end
                default: q_d = q_q;
            endcase
        end
    end

    // State register; reset overrides every other control.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q  <= RST_VAL;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.TC   = tc_q;
    assign bus.SO_L = q_q[WIDTH-1];
    assign bus.SO_R = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed and randomized check of univ_shift_reg at WIDTH=8 (defaults)
// and WIDTH=4 with a non-default preset value.
module tb_univ_shift_reg;

    logic clk;
    logic rst8, rst4;
    int   n_cmp;
    int   n_err;

    univ_shift_reg_if #(.WIDTH(8)) b8 ();
    univ_shift_reg_if #(.WIDTH(4)) b4 ();

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .CLK (clk),
        .RST (rst8),
        .bus (b8)
    );

    univ_shift_reg #(.WIDTH(4), .PRE_VAL(4'hA), .RST_VAL(4'h0)) dut4 (
        .CLK (clk),
        .RST (rst4),
        .bus (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one set of inputs to the 8-bit instance across one rising edge.
    task automatic cyc8(input logic rst, input logic pre, input logic e,
                        input logic [2:0] mode, input logic [7:0] d,
                        input logic sil, input logic sir);
        rst8    = rst;
        b8.PRE  = pre;
        b8.E    = e;
        b8.MODE = mode;
        b8.D    = d;
        b8.SI_L = sil;
        b8.SI_R = sir;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc4(input logic rst, input logic pre, input logic e,
                        input logic [2:0] mode, input logic [3:0] d);
        rst4    = rst;
        b4.PRE  = pre;
        b4.E    = e;
        b4.MODE = mode;
        b4.D    = d;
        b4.SI_L = 1'b0;
        b4.SI_R = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] q, input logic tc);
        check({tag, ".Q"}, 32'(b8.Q), 32'(q));
        check({tag, ".TC"}, 32'(b8.TC), 32'(tc));
    endtask

    task automatic chk4(input string tag, input logic [3:0] q, input logic tc);
        check({tag, ".Q"}, 32'(b4.Q), 32'(q));
        check({tag, ".TC"}, 32'(b4.TC), 32'(tc));
    endtask

    // Behavioural next state for the 8-bit instance: {TC, Q}.
    function automatic logic [8:0] model(input logic [7:0] q, input logic rst,
                                         input logic pre, input logic e,
                                         input logic [2:0] mode, input logic [7:0] d,
                                         input logic sil, input logic sir);
        logic [7:0] nq;
        logic       ntc;
        nq  = q;
        ntc = 1'b0;
        if (rst)       nq = 8'h00;
        else if (!pre) nq = 8'hFF;
        else if (e) begin
            case (mode)
                3'd1: nq = d;
                3'd2: nq = {q[6:0], sil};
                3'd3: nq = {sir, q[7:1]};
                3'd4: nq = {q[6:0], q[7]};
                3'd5: nq = {q[0], q[7:1]};
                3'd6: begin nq = q + 8'd1; ntc = (q == 8'hFF); end
                3'd7: begin nq = q - 8'd1; ntc = (q == 8'h00); end
                default: nq = q;
            endcase
        end
        return {ntc, nq};
    endfunction

    initial begin
        logic [7:0] m_q;
        logic       m_tc;
        logic [8:0] nx;
        logic       r_rst, r_pre, r_e, r_sil, r_sir;
        logic [2:0] r_mode;
        logic [7:0] r_d;

        n_cmp = 0;
        n_err = 0;
        rst8 = 1'b1; b8.PRE = 1'b1; b8.E = 1'b0; b8.MODE = 3'd0; b8.D = '0;
        b8.SI_L = 1'b0; b8.SI_R = 1'b0;
        rst4 = 1'b1; b4.PRE = 1'b1; b4.E = 1'b0; b4.MODE = 3'd0; b4.D = '0;
        b4.SI_L = 1'b0; b4.SI_R = 1'b0;

        // Reset beats preset, then preset alone.
        cyc8(1, 0, 1, 3'd1, 8'h55, 0, 0);  chk8("rst", 8'h00, 0);
        cyc8(0, 0, 1, 3'd1, 8'h55, 0, 0);  chk8("pre", 8'hFF, 0);

        // Load and serial shifts with serial outputs.
        cyc8(0, 1, 1, 3'd1, 8'hA5, 0, 0);  chk8("load_a5", 8'hA5, 0);
        check("load_a5.SO_L", 32'(b8.SO_L), 32'd1);
        check("load_a5.SO_R", 32'(b8.SO_R), 32'd1);
        cyc8(0, 1, 1, 3'd2, 8'h00, 1, 0);  chk8("shl", 8'h4B, 0);
        check("shl.SO_L", 32'(b8.SO_L), 32'd0);
        check("shl.SO_R", 32'(b8.SO_R), 32'd1);
        cyc8(0, 1, 1, 3'd3, 8'h00, 1, 0);  chk8("shr", 8'h25, 0);
        check("shr.SO_L", 32'(b8.SO_L), 32'd0);
        check("shr.SO_R", 32'(b8.SO_R), 32'd1);

        // Rotates.
        cyc8(0, 1, 1, 3'd1, 8'h81, 0, 0);  chk8("load_81", 8'h81, 0);
        cyc8(0, 1, 1, 3'd4, 8'h00, 0, 0);  chk8("rol", 8'h03, 0);
        cyc8(0, 1, 1, 3'd5, 8'h00, 0, 0);  chk8("ror", 8'h81, 0);

        // Up count through the wrap, then down count through the wrap.
        cyc8(0, 1, 1, 3'd1, 8'hFE, 0, 0);  chk8("load_fe", 8'hFE, 0);
        cyc8(0, 1, 1, 3'd6, 8'h00, 0, 0);  chk8("inc_ff", 8'hFF, 0);
        cyc8(0, 1, 1, 3'd6, 8'h00, 0, 0);  chk8("inc_wrap", 8'h00, 1);
        cyc8(0, 1, 1, 3'd6, 8'h00, 0, 0);  chk8("inc_01", 8'h01, 0);
        cyc8(0, 1, 1, 3'd1, 8'h00, 0, 0);  chk8("load_00", 8'h00, 0);
        cyc8(0, 1, 1, 3'd7, 8'h00, 0, 0);  chk8("dec_wrap", 8'hFF, 1);
        cyc8(0, 1, 1, 3'd7, 8'h00, 0, 0);  chk8("dec_fe", 8'hFE, 0);

        // Disabled: hold; preset still acts.
        cyc8(0, 1, 0, 3'd1, 8'h3C, 0, 0);  chk8("e0_hold", 8'hFE, 0);
        cyc8(0, 0, 0, 3'd1, 8'h3C, 0, 0);  chk8("e0_pre", 8'hFF, 0);

        // Disable right after a wrap pulse clears TC and holds Q.
        cyc8(0, 1, 1, 3'd6, 8'h00, 0, 0);  chk8("wrap2", 8'h00, 1);
        cyc8(0, 1, 0, 3'd6, 8'h00, 0, 0);  chk8("e0_tcclr", 8'h00, 0);

        // Reset in the middle of counting.
        cyc8(0, 1, 1, 3'd1, 8'h7D, 0, 0);  chk8("load_7d", 8'h7D, 0);
        cyc8(0, 1, 1, 3'd6, 8'h00, 0, 0);  chk8("inc_7e", 8'h7E, 0);
        cyc8(0, 1, 1, 3'd6, 8'h00, 0, 0);  chk8("inc_7f", 8'h7F, 0);
        cyc8(1, 1, 1, 3'd6, 8'h00, 0, 0);  chk8("rst_mid", 8'h00, 0);
        cyc8(0, 1, 0, 3'd0, 8'h00, 0, 0);

        // Narrow instance with a non-default preset.
        cyc4(1, 0, 1, 3'd1, 4'h5);  chk4("w4_rst", 4'h0, 0);
        cyc4(0, 0, 1, 3'd1, 4'h5);  chk4("w4_pre", 4'hA, 0);
        cyc4(0, 1, 1, 3'd1, 4'hE);  chk4("w4_load_e", 4'hE, 0);
        cyc4(0, 1, 1, 3'd6, 4'h0);  chk4("w4_inc_f", 4'hF, 0);
        cyc4(0, 1, 1, 3'd6, 4'h0);  chk4("w4_inc_wrap", 4'h0, 1);
        cyc4(0, 1, 1, 3'd6, 4'h0);  chk4("w4_inc_1", 4'h1, 0);
        cyc4(0, 1, 1, 3'd1, 4'h0);  chk4("w4_load_0", 4'h0, 0);
        cyc4(0, 1, 1, 3'd7, 4'h0);  chk4("w4_dec_wrap", 4'hF, 1);
        cyc4(0, 1, 1, 3'd7, 4'h0);  chk4("w4_dec_e", 4'hE, 0);

        // Random stimulus against the model; stop at the first disagreement.
        cyc8(1, 1, 0, 3'd0, 8'h00, 0, 0);
        m_q  = 8'h00;
        m_tc = 1'b0;
        for (int i = 0; i < 200; i++) begin
            r_rst  = ($urandom_range(0, 19) == 0);
            r_pre  = ($urandom_range(0, 15) != 0);
            r_e    = ($urandom_range(0, 5) != 0);
            r_mode = 3'($urandom_range(0, 7));
            r_d    = 8'($urandom_range(0, 255));
            r_sil  = 1'($urandom_range(0, 1));
            r_sir  = 1'($urandom_range(0, 1));
            if (i % 40 == 10) begin
                r_rst = 1'b0; r_pre = 1'b1; r_e = 1'b1; r_mode = 3'd1; r_d = 8'hFF;
            end
            if (i % 40 == 25) begin
                r_rst = 1'b0; r_pre = 1'b1; r_e = 1'b1; r_mode = 3'd1; r_d = 8'h00;
            end
            nx   = model(m_q, r_rst, r_pre, r_e, r_mode, r_d, r_sil, r_sir);
            m_q  = nx[7:0];
            m_tc = nx[8];
            cyc8(r_rst, r_pre, r_e, r_mode, r_d, r_sil, r_sir);
            check($sformatf("rand%0d", i),
                  {21'd0, b8.TC, b8.SO_L, b8.SO_R, b8.Q},
                  {21'd0, m_tc, m_q[7], m_q[0], m_q});
            if (n_err != 0) begin
                $display("random run stopped at cycle %0d", i);
                break;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter PRE_VAL, default {WIDTH{1'b1}}, giving the value loaded by preset.
REQ-003 The block SHALL have parameter RST_VAL, default {WIDTH{1'b0}}, giving the value loaded by reset.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port PRE, input, 1 bit: preset, synchronous and active-low.
REQ-007 The block SHALL have port E, input, 1 bit: operation enable, active-high.
REQ-008 The block SHALL have port MODE, input, 3 bits: operation select.
REQ-009 The block SHALL have port D, input, WIDTH bits: parallel load data.
REQ-010 The block SHALL have port SI_L, input, 1 bit: serial input, entering the LSB on shift-left.
REQ-011 The block SHALL have port SI_R, input, 1 bit: serial input, entering the MSB on shift-right.
REQ-012 The block SHALL have port Q, output, WIDTH bits: register contents.
REQ-013 The block SHALL have ports SO_L and SO_R, outputs, 1 bit each: SO_L = Q[WIDTH-1] and SO_R = Q[0], combinational from Q.
REQ-014 The block SHALL have port TC, output, 1 bit: registered terminal-count/wrap flag.

Function
REQ-015 Per rising CLK edge, priority SHALL be: RST=1, then PRE=0, then E=1, else hold.
REQ-016 PRE=0 with RST=0 SHALL load Q<=PRE_VAL and TC<=0, regardless of E and MODE.
REQ-017 E=0 with RST=0 and PRE=1 SHALL hold Q and SHALL force TC<=0.
REQ-018 With E=1, MODE SHALL select one of eight operations:
- 000 hold
- 001 Q<=D
- 010 Q<={Q[W-2:0],SI_L}
- 011 Q<={SI_R,Q[W-1:1]}
- 100 rotate left, Q<={Q[W-2:0],Q[W-1]}
- 101 rotate right, Q<={Q[0],Q[W-1:1]}
- 110 Q<=Q+1 modulo 2^WIDTH
- 111 Q<=Q-1 modulo 2^WIDTH
REQ-019 TC SHALL become 1 on an edge where E=1, MODE=110 and Q is all ones (Q wraps to 0).
REQ-020 TC SHALL become 1 on an edge where E=1, MODE=111 and Q=0 (Q wraps to all ones).
REQ-021 On every other edge TC SHALL become 0, so TC is a one-cycle pulse aligned with the wrapped Q value.
REQ-022 Every operation SHALL have a latency of one edge: Q reflects the operation immediately after the edge on which it is sampled.
REQ-023 Changes of MODE, D, SI_L or SI_R between edges SHALL have no effect on Q or TC.
REQ-024 Arithmetic SHALL be unsigned and WIDTH bits wide, with no carry or borrow output other than TC.

Reset
REQ-025 RST=1 SHALL load Q<=RST_VAL and TC<=0 on the next edge, overriding PRE, E, MODE and any operation in progress.
REQ-026 Before the first edge with RST=1 the state SHALL be undefined; no asynchronous path from RST, PRE or E to Q or TC SHALL exist.

Verification (WIDTH=8, default parameters unless noted)
REQ-027 The bench SHALL drive RST=1, PRE=0 for one edge -> Q=8'h00, TC=0; then RST=0, PRE=0 for one edge -> Q=8'hFF.
REQ-028 The bench SHALL apply MODE=001 with D=8'hA5 -> Q=8'hA5; then MODE=010 with SI_L=1 -> 8'h4B; then MODE=011 with SI_R=0 -> 8'h25; checking SO_L and SO_R each cycle.
REQ-029 The bench SHALL load 8'h81, apply MODE=100 -> 8'h03, then MODE=101 -> 8'h81.
REQ-030 The bench SHALL load 8'hFE and count up (MODE=110) -> Q/TC = FF/0, 00/1, 01/0; then load 8'h00 and count down (MODE=111) -> FF/1, FE/0.
REQ-031 The bench SHALL apply E=0 with MODE=001 and D=8'h3C -> Q unchanged, TC=0; then E=0 with PRE=0 -> Q=8'hFF.
REQ-032 The bench SHALL assert RST=1 mid count-up at Q=8'h7F -> Q=8'h00, TC=0 on the next edge.
REQ-033 The bench SHALL repeat the checks of REQ-027 and REQ-030 on an instance with WIDTH=4, PRE_VAL=4'hA -> preset gives 4'hA, and up-count wraps F->0 with TC=1.
REQ-034 The bench SHALL run 200 cycles of random stimulus compared against a reference model, stopping with an error message on the first mismatch.
